frame_pixel_engine: RTL and testbench

- Parametrised successor of the camera frame core: streams one frame from the input frame buffer (camera side) to the output frame buffer (VGA side), one pixel per clk25 cycle.
- Generalised in frame size, pixel widths and memory read latency.
- Adds start/free-run control, a stall input for LeNet back-pressure, and four per-frame pixel modes: passthrough, threshold, invert, centre crop.
- Reports busy and end-of-frame status.

---
 rtl/frame_pixel_engine.sv | 218 +++++++++++++++++++++
 tb/tb_frame_pixel_engine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pixel_engine.sv
// frame_pixel_engine: streams one frame from the camera-side frame buffer to
// the VGA-side frame buffer, one pixel per clk25 cycle, applying a per-frame
// pixel mode (pass, threshold, invert, centre crop).
// Optional feature macro: FRAME_STATS_EN adds hist_count, the number of
// nonzero pixels written in the last completed frame.
`timescale 1ns/1ps

module frame_pixel_engine #(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int DIN_W    = 8,
  parameter int DOUT_W   = 4,
  parameter int ADDR_W   = 19,
  parameter int READ_LAT = 1,
  parameter int CROP_W   = 320,
  parameter int CROP_H   = 240,
  parameter int FREE_RUN = 1
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic [1:0]        mode,
  input  logic [DIN_W-1:0]  thresh,
  input  logic [DIN_W-1:0]  din,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DOUT_W-1:0] dout,
  output logic              we,
  output logic              busy,
  output logic              frame_done
`ifdef FRAME_STATS_EN
  ,
  output logic [ADDR_W-1:0] hist_count
`endif
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_LO = XW'((WIDTH - CROP_W) / 2);
  localparam logic [XW-1:0] X_HI = XW'((WIDTH - CROP_W) / 2 + CROP_W - 1);
  localparam logic [YW-1:0] Y_LO = YW'((HEIGHT - CROP_H) / 2);
  localparam logic [YW-1:0] Y_HI = YW'((HEIGHT - CROP_H) / 2 + CROP_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rdAddr_q, rdAddr_d;
  logic [XW-1:0]       xPos_q, xPos_d;
  logic [YW-1:0]       yPos_q, yPos_d;
  logic [1:0]          mode_q;
  logic [DIN_W-1:0]    thresh_q;
  logic                issue, enterRun, inWindow;

  logic [READ_LAT-1:0]             pipeValid_q;
  logic [READ_LAT-1:0]             pipeWin_q;
  logic [READ_LAT-1:0][ADDR_W-1:0] pipeAddr_q;

  logic                we_q;
  logic [ADDR_W-1:0]   wrAddr_q;
  logic [DOUT_W-1:0]   dout_q;
  logic [DOUT_W-1:0]   pixel;

  assign inWindow = (xPos_q >= X_LO) && (xPos_q <= X_HI) &&
                    (yPos_q >= Y_LO) && (yPos_q <= Y_HI);

  // Next-state logic: read issue, address and x/y advance, and frame restart.
  always_comb begin
    state_d  = state_q;
    rdAddr_d = rdAddr_q;
    xPos_d   = xPos_q;
    yPos_d   = yPos_q;
    issue    = 1'b0;
    enterRun = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || (FREE_RUN != 0)) begin
          state_d  = RUN;
          enterRun = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          issue = 1'b1;
          if (rdAddr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            rdAddr_d = rdAddr_q + 1'b1;
          end
          if (xPos_q == X_LAST) begin
            xPos_d = '0;
            yPos_d = (yPos_q == Y_LAST) ? '0 : yPos_q + 1'b1;
          end else begin
            xPos_d = xPos_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pipeValid_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (FREE_RUN != 0) begin
          state_d  = RUN;
          enterRun = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enterRun) begin
      rdAddr_d = '0;
      xPos_d   = '0;
      yPos_d   = '0;
    end
  end

  // State, read address, x/y position, and per-frame mode/threshold latch.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rdAddr_q <= '0;
      xPos_q   <= '0;
      yPos_q   <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
    end else begin
      state_q  <= state_d;
      rdAddr_q <= rdAddr_d;
      xPos_q   <= xPos_d;
      yPos_q   <= yPos_d;
      if (enterRun) begin
        mode_q   <= mode;
        thresh_q <= thresh;
      end
    end
  end

  // Read-latency pipeline; it shifts every cycle so a stall becomes a bubble.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      pipeValid_q <= '0;
      pipeWin_q   <= '0;
      pipeAddr_q  <= '0;
    end else begin
      pipeValid_q[0] <= issue;
      pipeWin_q[0]   <= inWindow;
      pipeAddr_q[0]  <= rdAddr_q;
      for (int i = 1; i < READ_LAT; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        pipeWin_q[i]   <= pipeWin_q[i-1];
        pipeAddr_q[i]  <= pipeAddr_q[i-1];
      end
    end
  end

  // Pixel function applied to the memory data arriving at the pipeline tail.
  always_comb begin
    pixel = '0;
    case (mode_q)
      2'd0: pixel = din[DIN_W-1 -: DOUT_W];
      2'd1: pixel = (din >= thresh_q) ? {DOUT_W{1'b1}} : {DOUT_W{1'b0}};
      2'd2: pixel = ~din[DIN_W-1 -: DOUT_W];
      default: pixel = pipeWin_q[READ_LAT-1] ? din[DIN_W-1 -: DOUT_W] : {DOUT_W{1'b0}};
    endcase
  end

  // Registered write stage; address and data hold when nothing is written.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      wrAddr_q <= '0;
      dout_q   <= '0;
    end else begin
      we_q <= pipeValid_q[READ_LAT-1];
      if (pipeValid_q[READ_LAT-1]) begin
        wrAddr_q <= pipeAddr_q[READ_LAT-1];
        dout_q   <= pixel;
      end
    end
  end

  assign rd_addr    = rdAddr_q;
  assign wr_addr    = wrAddr_q;
  assign dout       = dout_q;
  assign we         = we_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign frame_done = (state_q == DONE);

`ifdef FRAME_STATS_EN
  logic [ADDR_W-1:0] histCnt_q, histOut_q;

  // Count nonzero written pixels; publish the total in the DONE cycle.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      histCnt_q <= '0;
      histOut_q <= '0;
    end else begin
      if (enterRun) begin
        histCnt_q <= '0;
      end else if (we_q && (dout_q != '0)) begin
        histCnt_q <= histCnt_q + 1'b1;
      end
      if (state_q == DONE) begin
        histOut_q <= histCnt_q;
      end
    end
  end

  assign hist_count = histOut_q;
`endif

endmodule

// File: tb/tb_frame_pixel_engine.sv
// Testbench for frame_pixel_engine: an 8x4 single-shot instance (read latency
// 1) and an 8x4 free-running instance (read latency 3), each fed by a
// behavioural frame memory and checked against a per-pixel reference model.
`timescale 1ns/1ps

module tb_frame_pixel_engine;

  localparam int W        = 8;
  localparam int H        = 4;
  localparam int NPIX     = W * H;
  localparam int DIN_W    = 8;
  localparam int DOUT_W   = 4;
  localparam int ADDR_W   = 6;
  localparam int CW       = 4;
  localparam int CH       = 2;
  localparam int LAT_A    = 1;
  localparam int LAT_B    = 3;
  localparam int PERIOD_B = NPIX + LAT_B + 2;

  logic clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  int cyc = 0;
  always @(posedge clk25) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic              rstA, startA, stallA, weA, busyA, doneA;
  logic [1:0]        modeA;
  logic [DIN_W-1:0]  threshA, dinA;
  logic [ADDR_W-1:0] rdAddrA, wrAddrA;
  logic [DOUT_W-1:0] doutA;
  logic              rstB, startB, stallB, weB, busyB, doneB;
  logic [1:0]        modeB;
  logic [DIN_W-1:0]  threshB, dinB;
  logic [ADDR_W-1:0] rdAddrB, wrAddrB;
  logic [DOUT_W-1:0] doutB;
`ifdef FRAME_STATS_EN
  logic [ADDR_W-1:0] histA, histB;
`endif

  frame_pixel_engine #(
    .WIDTH(W), .HEIGHT(H), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .ADDR_W(ADDR_W),
    .READ_LAT(LAT_A), .CROP_W(CW), .CROP_H(CH), .FREE_RUN(0)
  ) dutA (
    .clk25(clk25), .rst(rstA), .start(startA), .stall(stallA), .mode(modeA),
    .thresh(threshA), .din(dinA), .rd_addr(rdAddrA), .wr_addr(wrAddrA),
    .dout(doutA), .we(weA), .busy(busyA), .frame_done(doneA)
`ifdef FRAME_STATS_EN
    , .hist_count(histA)
`endif
  );

  frame_pixel_engine #(
    .WIDTH(W), .HEIGHT(H), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .ADDR_W(ADDR_W),
    .READ_LAT(LAT_B), .CROP_W(CW), .CROP_H(CH), .FREE_RUN(1)
  ) dutB (
    .clk25(clk25), .rst(rstB), .start(startB), .stall(stallB), .mode(modeB),
    .thresh(threshB), .din(dinB), .rd_addr(rdAddrB), .wr_addr(wrAddrB),
    .dout(doutB), .we(weB), .busy(busyB), .frame_done(doneB)
`ifdef FRAME_STATS_EN
    , .hist_count(histB)
`endif
  );

  // Frame memories with fixed read latency 1 (A) and 3 (B).
  logic [DIN_W-1:0] memA [NPIX];
  logic [DIN_W-1:0] memB [NPIX];
  logic [DIN_W-1:0] latB [LAT_B];

  always @(posedge clk25) begin
    dinA    <= memA[rdAddrA[4:0]];
    latB[0] <= memB[rdAddrB[4:0]];
    latB[1] <= latB[0];
    latB[2] <= latB[1];
  end
  assign dinB = latB[2];

  // Write monitors: every write and frame_done, stamped with its cycle number.
  int wAddrA[$], wDataA[$], wCycA[$];
  int wAddrB[$], wDataB[$], wCycB[$], fdB[$];

  always @(posedge clk25) begin
    #1;
    if (weA) begin
      wAddrA.push_back(int'(wrAddrA));
      wDataA.push_back(int'(doutA));
      wCycA.push_back(cyc);
    end
    if (weB) begin
      wAddrB.push_back(int'(wrAddrB));
      wDataB.push_back(int'(doutB));
      wCycB.push_back(cyc);
    end
    if (doneB) fdB.push_back(cyc);
  end

  // Reference pixel value from mode, threshold, memory word and pixel index.
  function automatic int refPixel(input int m, input int t, input int d, input int a);
    int x, y, hi, res;
    x  = a % W;
    y  = a / W;
    hi = d / (1 << (DIN_W - DOUT_W));
    case (m)
      0: res = hi;
      1: res = (d >= t) ? (1 << DOUT_W) - 1 : 0;
      2: res = ((1 << DOUT_W) - 1) - hi;
      default: res = (x >= (W - CW) / 2 && x < (W - CW) / 2 + CW &&
                      y >= (H - CH) / 2 && y < (H - CH) / 2 + CH) ? hi : 0;
    endcase
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame on instance A: start pulse, optional stall burst, optional
  // stray start pulses (mid-frame and in DONE), then full write-log check.
  task automatic applyStimulus(input int m, input int t, input int stallAt, input int stallLen,
                               input bit stallWithStart, input bit strayStarts, input string tag);
    int  s, remain, doneCyc, nz, n, extra, expDone;
    bit  used, seen;
    wAddrA.delete(); wDataA.delete(); wCycA.delete();
    @(negedge clk25);
    modeA   = 2'(m);
    threshA = 8'(t);
    startA  = 1'b1;
    stallA  = stallWithStart;
    s       = cyc;
    @(negedge clk25);
    startA  = 1'b0;
    modeA   = 2'($urandom);
    threshA = 8'($urandom);
    remain = 0; used = 1'b0; seen = 1'b0; doneCyc = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      if (remain > 0) begin
        remain--;
        if (remain == 0) stallA = 1'b0;
      end else if (!used && stallLen > 0 && busyA && int'(rdAddrA) == stallAt) begin
        stallA = 1'b1;
        used   = 1'b1;
        remain = stallLen;
      end
      if (strayStarts && k == 6) startA = 1'b1;
      if (strayStarts && k == 7) startA = 1'b0;
      if (doneA) begin
        seen    = 1'b1;
        doneCyc = cyc;
        if (strayStarts) startA = 1'b1;
      end
      @(negedge clk25);
    end
    startA = 1'b0;
    stallA = 1'b0;
    checkOutput({tag, " frame_done seen"}, 32'(seen), 1);
    repeat (3) @(negedge clk25);
    checkOutput({tag, " idle after frame"}, 32'(busyA), 0);
    checkOutput({tag, " write count"}, wAddrA.size(), NPIX);
    n  = (wAddrA.size() < NPIX) ? wAddrA.size() : NPIX;
    nz = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (refPixel(m, t, int'(memA[i]), i) != 0) nz++;
    end
    for (int i = 0; i < n; i++) begin
      extra = (stallLen > 0 && i >= stallAt) ? stallLen : 0;
      checkOutput($sformatf("%s addr[%0d]", tag, i), wAddrA[i], i);
      checkOutput($sformatf("%s dout[%0d]", tag, i), wDataA[i], refPixel(m, t, int'(memA[i]), i));
      checkOutput($sformatf("%s wcyc[%0d]", tag, i), wCycA[i] - s, 1 + i + extra + LAT_A + 1);
    end
    expDone = 1 + (NPIX - 1) + ((stallLen > 0) ? stallLen : 0) + LAT_A + 2;
    checkOutput({tag, " frame_done cycle"}, doneCyc - s, expDone);
`ifdef FRAME_STATS_EN
    checkOutput({tag, " hist_count"}, 32'(histA), nz);
`endif
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r, n, cnt, tB, mf, tf;
    int b;
    rstA = 1'b1; startA = 1'b0; stallA = 1'b0; modeA = 2'd0; threshA = '0;
    rstB = 1'b1; startB = 1'b0; stallB = 1'b0; modeB = 2'd0; threshB = '0;
    for (int a = 0; a < NPIX; a++) begin
      memA[a] = '0;
      memB[a] = '0;
    end
    repeat (3) @(negedge clk25);

    // Reset state on both instances.
    checkOutput("rst rd_addr", 32'(rdAddrA), 0);
    checkOutput("rst wr_addr", 32'(wrAddrA), 0);
    checkOutput("rst dout", 32'(doutA), 0);
    checkOutput("rst we", 32'(weA), 0);
    checkOutput("rst busy", 32'(busyA), 0);
    checkOutput("rst frame_done", 32'(doneA), 0);
    checkOutput("rst B busy", 32'(busyB), 0);
    checkOutput("rst B we", 32'(weB), 0);
    checkOutput("rst B rd_addr", 32'(rdAddrB), 0);
`ifdef FRAME_STATS_EN
    checkOutput("rst hist_count", 32'(histA), 0);
`endif

    // Single-shot instance stays idle without a start pulse.
    rstA = 1'b0;
    repeat (4) @(negedge clk25);
    checkOutput("idle without start", 32'(busyA), 0);

    // Passthrough, din = addr*16.
    for (int a = 0; a < NPIX; a++) memA[a] = 8'(a * 16);
    applyStimulus(0, 0, 0, 0, 1'b0, 1'b0, "pass");

    // Three-cycle stall at address 10, with ignored starts mid-frame and in DONE.
    applyStimulus(0, 0, 10, 3, 1'b0, 1'b1, "stall");

    // Threshold 0x80 on alternating 0x7F/0x80.
    for (int a = 0; a < NPIX; a++) memA[a] = (a % 2 == 1) ? 8'h80 : 8'h7F;
    applyStimulus(1, 'h80, 0, 0, 1'b0, 1'b0, "thresh");

    // Centre crop with nonzero upper nibbles; start and stall together.
    for (int a = 0; a < NPIX; a++) memA[a] = 8'(16 + $urandom_range(0, 239));
    applyStimulus(3, 0, 0, 2, 1'b1, 1'b0, "crop");
    cnt = 0;
    for (int i = 0; i < wDataA.size(); i++) if (wDataA[i] != 0) cnt++;
    checkOutput("crop nonzero count", cnt, CW * CH);

    // Invert on random data with a random stall burst.
    for (int a = 0; a < NPIX; a++) memA[a] = 8'($urandom);
    applyStimulus(2, 0, $urandom_range(1, NPIX - 2), $urandom_range(1, 4), 1'b0, 1'b0, "invert");

    // Reset at rd_addr 20 aborts the frame immediately.
    @(negedge clk25);
    modeA = 2'd0; startA = 1'b1;
    @(negedge clk25);
    startA = 1'b0;
    for (int k = 0; k < 100 && int'(rdAddrA) != 20; k++) @(negedge clk25);
    checkOutput("abort reached addr", 32'(rdAddrA), 20);
    rstA = 1'b1;
    #1;
    checkOutput("abort we", 32'(weA), 0);
    checkOutput("abort busy", 32'(busyA), 0);
    n = wAddrA.size();
    repeat (3) @(negedge clk25);
    rstA = 1'b0;
    repeat (4) @(negedge clk25);
    checkOutput("abort no writes", wAddrA.size(), n);
    checkOutput("abort stays idle", 32'(busyA), 0);

    // Restart after abort: threshold mode with 12 bright pixels.
    for (int a = 0; a < NPIX; a++) memA[a] = 8'($urandom_range(0, 127));
    cnt = 0;
    while (cnt < 12) begin
      b = $urandom_range(0, NPIX - 1);
      if (memA[b] < 8'h80) begin
        memA[b] = 8'(128 + $urandom_range(0, 127));
        cnt++;
      end
    end
    applyStimulus(1, 'h80, 0, 0, 1'b0, 1'b0, "restart");

    // Free-running instance: three back-to-back frames, mode changed mid-frame.
    for (int a = 0; a < NPIX; a++) memB[a] = 8'($urandom);
    tB = $urandom_range(0, 255);
    @(negedge clk25);
    rstB = 1'b0;
    r = cyc;
    for (int k = 0; k < 400 && fdB.size() < 3; k++) begin
      @(negedge clk25);
      if (cyc == r + 15) modeB = 2'd2;
      if (cyc == r + 15 + PERIOD_B) begin
        modeB   = 2'd1;
        threshB = 8'(tB);
      end
    end
    rstB = 1'b1;
    checkOutput("B frame_done count", fdB.size(), 3);
    for (int f = 0; f < fdB.size() && f < 3; f++) begin
      checkOutput($sformatf("B frame_done[%0d] cycle", f), fdB[f] - r, PERIOD_B * (f + 1));
    end
    checkOutput("B enough writes", 32'(wAddrB.size() >= 3 * NPIX), 1);
    for (int i = 0; i < wAddrB.size() && i < 3 * NPIX; i++) begin
      mf = (i / NPIX == 0) ? 0 : (i / NPIX == 1) ? 2 : 1;
      tf = (i / NPIX == 2) ? tB : 0;
      checkOutput($sformatf("B addr[%0d]", i), wAddrB[i], i % NPIX);
      checkOutput($sformatf("B dout[%0d]", i), wDataB[i],
                  refPixel(mf, tf, int'(memB[i % NPIX]), i % NPIX));
      checkOutput($sformatf("B wcyc[%0d]", i), wCycB[i] - r,
                  1 + PERIOD_B * (i / NPIX) + (i % NPIX) + LAT_B + 1);
    end
    #1;
    checkOutput("B busy in reset", 32'(busyB), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
